m2: RTL and testbench
=====================

M2 (OPERAND-1 FORWARDING MUX) -- requirements
Module: m2

Interface
REQ-001 Parameter WIDTH, default 16, data width of all operand/result buses.
REQ-002 Parameter CNT_W, default 16, width of each forwarding statistics counter.
REQ-003 clk  input  1  single clock; all sequential logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_op1_buff2  input  WIDTH  operand 1 from pipeline buffer 2 (register-file value).
REQ-006 in_alu_out_buff3  input  WIDTH  ALU result from buffer 3 (EX forwarding path).
REQ-007 in_m5_m2  input  WIDTH  value from mux5 (writeback forwarding path).
REQ-008 in_cntrl_m2  input  2  forwarding select.
REQ-009 stat_clr  input  1  synchronous clear of statistics counters.
REQ-010 out_m2  output  WIDTH  selected operand, combinational.
REQ-011 out_m2_q  output  WIDTH  out_m2 registered one cycle.
REQ-012 fwd_cnt_alu  output  CNT_W  count of cycles selecting the ALU path.
REQ-013 fwd_cnt_m5  output  CNT_W  count of cycles selecting the mux5 path.

Function
REQ-014 out_m2 SHALL be purely combinational, zero latency, changing in the same delta as any input.
REQ-015 in_cntrl_m2 = 00 SHALL select in_op1_buff2.
REQ-016 in_cntrl_m2 = 01 SHALL select in_alu_out_buff3.
REQ-017 in_cntrl_m2 = 10 SHALL select in_m5_m2.
REQ-018 in_cntrl_m2 = 11 SHALL select in_op1_buff2 (no forwarding).
REQ-019 Any X/Z on in_cntrl_m2 SHALL not be resolved by design; no output guarantee beyond simulator propagation.
REQ-020 out_m2_q SHALL load out_m2 on every rising clk edge while rst_n is high.
REQ-021 fwd_cnt_alu SHALL increment by 1 on each rising edge where in_cntrl_m2 = 01; fwd_cnt_m5 likewise for 10.
REQ-022 Counters SHALL saturate at all-ones and SHALL not wrap.
REQ-023 stat_clr high at a rising edge SHALL zero both counters, taking priority over increment in that cycle.
REQ-024 Selects 00 and 11 SHALL not change either counter.

Reset
REQ-025 rst_n low SHALL immediately (asynchronously) force out_m2_q, fwd_cnt_alu and fwd_cnt_m5 to 0.
REQ-026 out_m2 SHALL remain a live combinational function of inputs during reset.
REQ-027 Reset deassertion SHALL take effect at the first rising clk edge with rst_n high; reset asserted mid-count SHALL discard count.

Configuration
REQ-028 Macro M2_FWD_STATS_EN defined: counters and stat_clr logic per REQ-021..REQ-024 compiled in.
REQ-029 Macro M2_FWD_STATS_EN undefined: fwd_cnt_alu and fwd_cnt_m5 SHALL be tied to 0, stat_clr ignored, no counter flops; mux and out_m2_q unchanged.

Verification
REQ-030 cntrl=01, alu=16'b0100000010001101, others differing -> out_m2=16'b0100000010001101 same timestep.
REQ-031 cntrl=11, buff2=16'b0000111010101000, m5=16'hFFFF, alu=16'h0000 -> out_m2=16'b0000111010101000.
REQ-032 cntrl=10, m5=16'hFFFF, buff2=16'h0F0F -> out_m2=16'hFFFF; cntrl=00 -> out_m2=16'h0F0F; next edge out_m2_q=16'h0F0F.
REQ-033 M2_FWD_STATS_EN defined, cntrl=01 for 5 edges then 10 for 3 edges -> fwd_cnt_alu=5, fwd_cnt_m5=3; stat_clr one edge with cntrl=01 -> both 0.
REQ-034 CNT_W=4, cntrl=01 for 20 edges -> fwd_cnt_alu holds 15.
REQ-035 Counts nonzero, rst_n pulsed low between edges -> out_m2_q and counters 0 immediately, out_m2 still tracks inputs.

Source files
------------

// File: rtl/m2_if.sv
// Operand-1 forwarding mux bus: operand sources, select, stats clear and results.
// master drives sources/select/clear, slave (the mux) drives results and counters.
interface m2_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
);
    logic [WIDTH-1:0] in_op1_buff2;
    logic [WIDTH-1:0] in_alu_out_buff3;
    logic [WIDTH-1:0] in_m5_m2;
    logic [1:0]       in_cntrl_m2;
    logic             stat_clr;
    logic [WIDTH-1:0] out_m2;
    logic [WIDTH-1:0] out_m2_q;
    logic [CNT_W-1:0] fwd_cnt_alu;
    logic [CNT_W-1:0] fwd_cnt_m5;

    modport master (
        output in_op1_buff2, in_alu_out_buff3, in_m5_m2, in_cntrl_m2, stat_clr,
        input  out_m2, out_m2_q, fwd_cnt_alu, fwd_cnt_m5
    );

    modport slave (
        input  in_op1_buff2, in_alu_out_buff3, in_m5_m2, in_cntrl_m2, stat_clr,
        output out_m2, out_m2_q, fwd_cnt_alu, fwd_cnt_m5
    );
endinterface

// File: rtl/m2.sv
// Operand-1 forwarding mux with registered copy and optional saturating forwarding
// statistics, compiled in only when M2_FWD_STATS_EN is defined.
module m2 #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic clk,
    input  logic rst_n,
    m2_if.slave  bus
);

    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] out_q;

    // 11 deliberately falls back to the register-file operand (no forwarding)
    always_comb begin
        out_d = bus.in_op1_buff2;
        case (bus.in_cntrl_m2)
            2'b01:   out_d = bus.in_alu_out_buff3;
            2'b10:   out_d = bus.in_m5_m2;
            default: out_d = bus.in_op1_buff2;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign bus.out_m2   = out_d;
    assign bus.out_m2_q = out_q;

`ifdef M2_FWD_STATS_EN
    logic [CNT_W-1:0] cnt_alu_d;
    logic [CNT_W-1:0] cnt_alu_q;
    logic [CNT_W-1:0] cnt_m5_d;
    logic [CNT_W-1:0] cnt_m5_q;

    // clear wins over increment; counters stick at all-ones
    always_comb begin
        cnt_alu_d = cnt_alu_q;
        cnt_m5_d  = cnt_m5_q;
        if (bus.stat_clr) begin
            cnt_alu_d = '0;
            cnt_m5_d  = '0;
        end else begin
            if (bus.in_cntrl_m2 == 2'b01 && cnt_alu_q != {CNT_W{1'b1}}) begin
                cnt_alu_d = cnt_alu_q + CNT_W'(1);
            end
            if (bus.in_cntrl_m2 == 2'b10 && cnt_m5_q != {CNT_W{1'b1}}) begin
                cnt_m5_d = cnt_m5_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_alu_q <= '0;
            cnt_m5_q  <= '0;
        end else begin
            cnt_alu_q <= cnt_alu_d;
            cnt_m5_q  <= cnt_m5_d;
        end
    end

    assign bus.fwd_cnt_alu = cnt_alu_q;
    assign bus.fwd_cnt_m5  = cnt_m5_q;
`else
    logic unused_stat_clr;

    assign unused_stat_clr = bus.stat_clr;
    assign bus.fwd_cnt_alu = '0;
    assign bus.fwd_cnt_m5  = '0;
`endif

endmodule

// File: tb/tb_m2.sv
// Directed bench for the forwarding mux: vector table for select decoding and the
// registered copy, plus sequences for counting, saturation, clear and async reset.
module tb_m2;

`ifdef M2_FWD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk;
    logic rst_n;

    m2_if #(.WIDTH(16), .CNT_W(16)) bus16 ();
    m2_if #(.WIDTH(16), .CNT_W(4))  bus4 ();

    m2 #(.WIDTH(16), .CNT_W(16)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(bus16));
    m2 #(.WIDTH(16), .CNT_W(4))  u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  cntrl;
        logic [15:0] buff2;
        logic [15:0] alu;
        logic [15:0] m5;
        logic [15:0] exp_out;
    } vec_t;

    int n_pass;
    int n_total;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [1:0] c, input logic [15:0] b2,
                          input logic [15:0] al, input logic [15:0] m5v);
        bus16.in_cntrl_m2      = c;
        bus16.in_op1_buff2     = b2;
        bus16.in_alu_out_buff3 = al;
        bus16.in_m5_m2         = m5v;
        bus4.in_cntrl_m2       = c;
        bus4.in_op1_buff2      = b2;
        bus4.in_alu_out_buff3  = al;
        bus4.in_m5_m2          = m5v;
    endtask

    task automatic set_clr(input logic v);
        bus16.stat_clr = v;
        bus4.stat_clr  = v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ex(input int n);
        return STATS ? 32'(n) : 32'd0;
    endfunction

    vec_t vecs[8];

    initial begin
        n_pass  = 0;
        n_total = 0;

        vecs[0] = '{2'b01, 16'h1234, 16'h408D, 16'hBEEF, 16'h408D};
        vecs[1] = '{2'b11, 16'h0EA8, 16'h0000, 16'hFFFF, 16'h0EA8};
        vecs[2] = '{2'b10, 16'h0F0F, 16'h1111, 16'hFFFF, 16'hFFFF};
        vecs[3] = '{2'b00, 16'h0F0F, 16'h1111, 16'hFFFF, 16'h0F0F};
        vecs[4] = '{2'b00, 16'hA5A5, 16'h5A5A, 16'h3C3C, 16'hA5A5};
        vecs[5] = '{2'b01, 16'hA5A5, 16'h5A5A, 16'h3C3C, 16'h5A5A};
        vecs[6] = '{2'b10, 16'hA5A5, 16'h5A5A, 16'h3C3C, 16'h3C3C};
        vecs[7] = '{2'b11, 16'hA5A5, 16'h5A5A, 16'h3C3C, 16'hA5A5};

        // reset state, mux live during reset
        rst_n = 1'b0;
        set_clr(1'b0);
        set_in(2'b01, 16'h1111, 16'h2222, 16'h3333);
        #1;
        chk("rst_out_q", 32'(bus16.out_m2_q), 32'h0);
        chk("rst_cnt_alu", 32'(bus16.fwd_cnt_alu), 32'h0);
        chk("rst_cnt_m5", 32'(bus16.fwd_cnt_m5), 32'h0);
        chk("rst_out_live", 32'(bus16.out_m2), 32'h2222);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            set_in(vecs[i].cntrl, vecs[i].buff2, vecs[i].alu, vecs[i].m5);
            #1;
            chk($sformatf("vec%0d_out", i), 32'(bus16.out_m2), 32'(vecs[i].exp_out));
            step();
            chk($sformatf("vec%0d_out_q", i), 32'(bus16.out_m2_q), 32'(vecs[i].exp_out));
        end
        chk("tbl_cnt_alu", 32'(bus16.fwd_cnt_alu), ex(2));
        chk("tbl_cnt_m5", 32'(bus16.fwd_cnt_m5), ex(2));

        // clear with select 10 active: clear must win
        set_in(2'b10, 16'h0001, 16'h0002, 16'h0003);
        set_clr(1'b1);
        step();
        set_clr(1'b0);
        chk("clr_cnt_alu", 32'(bus16.fwd_cnt_alu), 32'h0);
        chk("clr_cnt_m5", 32'(bus16.fwd_cnt_m5), 32'h0);

        set_in(2'b01, 16'h0001, 16'h0002, 16'h0003);
        repeat (5) step();
        set_in(2'b10, 16'h0001, 16'h0002, 16'h0003);
        repeat (3) step();
        chk("cnt5_alu", 32'(bus16.fwd_cnt_alu), ex(5));
        chk("cnt3_m5", 32'(bus16.fwd_cnt_m5), ex(3));

        set_in(2'b00, 16'h0001, 16'h0002, 16'h0003);
        step();
        set_in(2'b11, 16'h0001, 16'h0002, 16'h0003);
        step();
        chk("hold_cnt_alu", 32'(bus16.fwd_cnt_alu), ex(5));
        chk("hold_cnt_m5", 32'(bus16.fwd_cnt_m5), ex(3));

        set_in(2'b01, 16'h0001, 16'h0002, 16'h0003);
        set_clr(1'b1);
        step();
        set_clr(1'b0);
        chk("clr01_cnt_alu", 32'(bus16.fwd_cnt_alu), 32'h0);
        chk("clr01_cnt_m5", 32'(bus16.fwd_cnt_m5), 32'h0);

        // 20 ALU selects: 4-bit counter saturates at 15, 16-bit one reaches 20
        repeat (20) step();
        chk("sat4_cnt_alu", 32'(bus4.fwd_cnt_alu), ex(15));
        chk("sat4_cnt_m5", 32'(bus4.fwd_cnt_m5), 32'h0);
        chk("cnt20_alu", 32'(bus16.fwd_cnt_alu), ex(20));

        // async reset mid-cycle with nonzero counts
        set_in(2'b10, 16'h0001, 16'h0002, 16'h0003);
        repeat (2) step();
        chk("pre_rst_cnt_m5", 32'(bus16.fwd_cnt_m5), ex(2));
        rst_n = 1'b0;
        #1;
        chk("arst_out_q", 32'(bus16.out_m2_q), 32'h0);
        chk("arst_cnt_alu", 32'(bus16.fwd_cnt_alu), 32'h0);
        chk("arst_cnt_m5", 32'(bus16.fwd_cnt_m5), 32'h0);
        set_in(2'b01, 16'hAAAA, 16'hC0DE, 16'h5555);
        #1;
        chk("arst_out_live", 32'(bus16.out_m2), 32'hC0DE);
        rst_n = 1'b1;
        #1;
        chk("rel_out_q_held", 32'(bus16.out_m2_q), 32'h0);
        step();
        chk("rel_out_q", 32'(bus16.out_m2_q), 32'hC0DE);
        chk("rel_cnt_alu", 32'(bus16.fwd_cnt_alu), ex(1));
        chk("rel_cnt_m5", 32'(bus16.fwd_cnt_m5), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
